if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the pipelined CPU. It holds the program counter, issues requests to the instruction memory/cache over a req/ack handshake, and drives the IF/ID pipeline register consumed directly by the decode stage. It honours the decode-stage `stall`, applies branch/jump redirects (`flush`) by inserting NOP bubbles, and absorbs instruction returns that arrive during a stall in a one-entry hold buffer.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `NOP_INST`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`).

Ports:
- `clk_50`  in  1  stage clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  from decode hazard detection; holds PC and IF/ID.
- `flush`  in  1  taken-branch/jump redirect from execute.
- `target`  in  32  redirect address, valid when `flush`=1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1 and `imem_ack`=0.
- `imem_ack`  in  1  response valid; may assert in the same cycle as `imem_req` (hit) or any later cycle (miss).
- `imem_rdata`  in  32  instruction, valid when `imem_ack`=1.
- `INST`  out  32  IF/ID instruction to decode.
- `PC_ID`  out  32  PC of `INST`.
- `valid_id`  out  1  `INST` is a real fetched instruction (0 = bubble).

## Operation
- The stage has three states:
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - DRAIN: `imem_req`=1, `imem_addr`=`drain_addr`.
  - HOLD: `imem_req`=0.
- Reset (`rst`=1 at an edge):
  - `pc`=`RESET_PC`, state FETCH, `drain_addr`=0, hold buffer cleared.
  - `INST`=`NOP_INST`, `PC_ID`=0, `valid_id`=0.
  - `imem_req`=0 while `rst`=1. This overrides all other inputs, including mid-miss; an ack arriving during reset is ignored.
- Priority each cycle: `rst` > `flush` > `stall` > normal.
- FETCH, ack=1, no stall/flush: IF/ID <= {`imem_rdata`, `pc`, 1}; `pc`<=`pc`+4.
- FETCH, ack=0, stall=0: IF/ID <= {`NOP_INST`, `pc`, 0}; `pc` unchanged.
- FETCH, ack=0, stall=1: IF/ID and `pc` unchanged.
- FETCH, ack=1, stall=1:
  - Hold buffer <= {`imem_rdata`, `pc`}; `pc`<=`pc`+4.
  - Go to HOLD; IF/ID unchanged.
- HOLD, stall=1: no change.
- HOLD, stall=0: IF/ID <= {buffer, 1}; go to FETCH.
- Flush, any state:
  - IF/ID <= {`NOP_INST`, 0, 0}; `pc` <= {`target[31:2]`, 2'b00}.
  - FETCH with ack=0: `drain_addr`<=`pc`, go to DRAIN, because the memory request is outstanding and its address must stay stable.
  - FETCH with ack=1: returned data is dropped; stay in FETCH.
  - HOLD: buffer is discarded; go to FETCH.
  - DRAIN: `pc` is updated to the new target; stay in DRAIN.
- DRAIN, no flush:
  - IF/ID <= bubble unless `stall`=1, in which case IF/ID holds.
  - On ack, data is dropped and the state goes to FETCH (`pc` already holds the target).
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- `imem_req`/`imem_addr` are combinational from state and registers only; there is no combinational path from `imem_ack` or `stall`.

## Timing
- Hit latency: a request in cycle N with ack in cycle N gives `INST` valid in cycle N+1. Throughput is 1 instruction/cycle.
- Miss: an ack in cycle N+k gives `INST` in cycle N+k+1. Bubbles (`valid_id`=0) are output in between unless stalled.
- Flush in cycle N: the bubble is on IF/ID in N+1. The first fetch of `target` is in N+1 (from FETCH/HOLD) or in the cycle after the drain ack.
- The stall-release instruction from HOLD appears on IF/ID one cycle after `stall` falls. There is no refetch and no lost or duplicated instruction.
- All outputs are registered except `imem_req`/`imem_addr`.

## Test plan
- Reset, then constant ack=1 with `imem_rdata`=`addr`^32'hA5A5_0000:
  - `imem_req`=0 during reset.
  - Then `PC_ID`=0,4,8,… on consecutive cycles with matching `INST` and `valid_id`=1.
- ack delayed 3 cycles on addr 0x8:
  - `imem_addr` is held at 0x8 for 4 cycles.
  - Three bubbles follow, then `INST` for 0x8, then 0xC in the next cycle.
- `stall`=1 for 2 cycles while ack=1 at addr 0x10:
  - IF/ID holds the 0xC instruction; `imem_req`=0 in HOLD.
  - After release, the 0x10 instruction appears, then 0x14 is fetched. No duplicates.
- `flush` with `target`=0x100 during a pending miss on 0x20:
  - `imem_addr` stays 0x20 until ack and that data is dropped.
  - The next request is 0x100; bubbles appear meanwhile; `PC_ID`=0x100 is the first valid instruction.
- `flush`+`stall` in the same cycle with `target`=0x203:
  - The flush wins and the bubble is inserted.
  - Fetch resumes at 0x200.
- `pc`=0xFFFF_FFFC with ack=1: the next `imem_addr` is 0x0000_0000. `rst` asserted mid-miss: state returns to FETCH at `RESET_PC` and a late ack is ignored.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem req/ack handshake, IF/ID register,
// stall hold buffer and flush/drain handling for an outstanding miss.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] INST,
  output logic [31:0] PC_ID,
  output logic        valid_id
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{inst: NOP_INST, pc: 32'd0, valid: 1'b0};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_q, drain_d;
  logic [31:0] hinst_q, hinst_d;
  logic [31:0] hpc_q, hpc_d;
  if_id_t      ifid_q, ifid_d;

  logic [31:0] pc_inc;
  logic [31:0] tgt_al;

  assign pc_inc = pc_q + 32'd4;
  assign tgt_al = {target[31:2], 2'b00};

  // Request is driven from registered state only; rst gates it off.
  assign imem_req  = !rst && (state_q != HOLD);
  assign imem_addr = (state_q == DRAIN) ? drain_q : pc_q;

  assign INST     = ifid_q.inst;
  assign PC_ID    = ifid_q.pc;
  assign valid_id = ifid_q.valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drain_d = drain_q;
    hinst_d = hinst_q;
    hpc_d   = hpc_q;
    ifid_d  = ifid_q;
    if (flush) begin
      ifid_d = BUBBLE;
      pc_d   = tgt_al;
      unique case (state_q)
        FETCH: begin
          if (!imem_ack) begin
            drain_d = pc_q;
            state_d = DRAIN;
          end
        end
        HOLD:    state_d = FETCH;
        DRAIN:   state_d = DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          unique case (1'b1)
            imem_ack && !stall: begin
              ifid_d = '{inst: imem_rdata, pc: pc_q, valid: 1'b1};
              pc_d   = pc_inc;
            end
            imem_ack && stall: begin
              hinst_d = imem_rdata;
              hpc_d   = pc_q;
              pc_d    = pc_inc;
              state_d = HOLD;
            end
            !imem_ack && !stall: begin
              ifid_d = '{inst: NOP_INST, pc: pc_q, valid: 1'b0};
            end
            default: ;
          endcase
        end
        HOLD: begin
          if (!stall) begin
            ifid_d  = '{inst: hinst_q, pc: hpc_q, valid: 1'b1};
            state_d = FETCH;
          end
        end
        DRAIN: begin
          if (!stall) ifid_d = BUBBLE;
          // pc already holds the redirect target; the stale data is dropped.
          if (imem_ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      drain_q <= 32'd0;
      hinst_q <= 32'd0;
      hpc_q   <= 32'd0;
      ifid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      hinst_q <= hinst_d;
      hpc_q   <= hpc_d;
      ifid_q  <= ifid_d;
    end
  end

endmodule
